uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register so a
// second byte can be queued while a frame is on the wire and sent with no
// idle gap between frames.
module uart_tx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_txd,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic [1:0] o_state
);

    // Cycles per serial bit; derived, never set from outside.
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W_MIN    = $clog2(CLKS_PER_BIT);
    localparam int CNT_W        = (CNT_W_MIN > 20) ? CNT_W_MIN : 20;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             txd_q, txd_d;
    logic             done_q, done_d;

    logic             accept;
    logic             bit_end;

    // Handshake: i_tx_start is a valid strobe for i_tx_data and o_tx_ready is
    // the ready; a byte is taken on a rising edge only when both are high.
    // A strobe while ready is low is dropped with no effect. Ready depends
    // solely on registered state (holding register empty), never on
    // i_tx_start, so there is no combinational loop through the requester.
    assign accept  = i_tx_start && !hold_vld_q;
    assign bit_end = (baud_q == LAST_TICK);

    // State and datapath registers; reset forces the line idle and drops
    // both the byte in flight and any held byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    // Next-state, bit timing, shift/hold movement and registered line value.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        txd_d      = txd_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                // Holding register is always empty here, so the byte goes
                // straight to the shifter and the start bit begins next edge.
                if (accept) begin
                    state_d = START;
                    shift_d = i_tx_data;
                    txd_d   = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
                if (accept) begin
                    hold_d     = i_tx_data;
                    hold_vld_d = 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
                if (accept) begin
                    hold_d     = i_tx_data;
                    hold_vld_d = 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    done_d = 1'b1;
                    if (hold_vld_q) begin
                        // Queued byte follows with no idle cycle.
                        state_d    = START;
                        shift_d    = hold_q;
                        hold_vld_d = 1'b0;
                        txd_d      = 1'b0;
                    end else if (accept) begin
                        // Request on the final stop cycle bypasses the
                        // holding register and starts immediately.
                        state_d = START;
                        shift_d = i_tx_data;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                    if (accept) begin
                        hold_d     = i_tx_data;
                        hold_vld_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign o_tx_ready = !hold_vld_q;
    assign o_txd      = txd_q;
    assign o_tx_busy  = (state_q != IDLE);
    assign o_tx_done  = done_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx at 10 clocks per bit.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       i_tx_start;
    logic [7:0] i_tx_data;
    logic       o_tx_ready;
    logic       o_txd;
    logic       o_tx_busy;
    logic       o_tx_done;
    logic [1:0] o_state;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    uart_tx #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tx_start(i_tx_start),
        .i_tx_data (i_tx_data),
        .o_tx_ready(o_tx_ready),
        .o_txd     (o_txd),
        .o_tx_busy (o_tx_busy),
        .o_tx_done (o_tx_done),
        .o_state   (o_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one accepted request from idle; returns at the negedge that
    // starts cycle 0 of the start bit.
    task automatic request(input logic [7:0] b);
        @(negedge clk);
        i_tx_start = 1'b1;
        i_tx_data  = b;
        exp_q.push_back(b);
        @(negedge clk);
        i_tx_start = 1'b0;
    endtask

    // Watch one 100-cycle frame starting at its cycle 0. Optionally injects
    // up to two requests at given cycle indices and toggles i_tx_data on all
    // other cycles. Ends on the cycle after the last stop cycle.
    task automatic watch_frame(input string tag,
                               input int inj1_at, input logic [7:0] inj1_b,
                               input int inj2_at, input logic [7:0] inj2_b,
                               input bit toggle, input int exp_ready_hi);
        logic [7:0] b;
        logic [9:0] frame;
        int match;
        int busy_lo;
        int done_hi;
        int ready_hi;
        int idx;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 32'd0, 32'd1);
            return;
        end
        b        = exp_q.pop_front();
        frame    = {1'b1, b, 1'b0};
        busy_lo  = 0;
        done_hi  = 0;
        ready_hi = 0;
        check({tag, " state"}, 32'(o_state), 32'd1);
        for (int k = 0; k < 10; k++) begin
            match = 0;
            for (int c = 0; c < 10; c++) begin
                idx = k * 10 + c;
                if (o_txd == frame[k]) match++;
                if (!o_tx_busy) busy_lo++;
                if (o_tx_done && idx > 0) done_hi++;
                if (o_tx_ready) ready_hi++;
                i_tx_start = 1'b0;
                if (toggle) i_tx_data = ~i_tx_data;
                if (idx == inj1_at) begin
                    i_tx_start = 1'b1;
                    i_tx_data  = inj1_b;
                end else if (idx == inj2_at) begin
                    i_tx_start = 1'b1;
                    i_tx_data  = inj2_b;
                end
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", tag, k), 32'(match), 32'd10);
        end
        i_tx_start = 1'b0;
        check({tag, " busy"}, 32'(busy_lo), 32'd0);
        check({tag, " early_done"}, 32'(done_hi), 32'd0);
        check({tag, " ready"}, 32'(ready_hi), 32'(exp_ready_hi));
        check({tag, " done"}, 32'(o_tx_done), 32'd1);
    endtask

    // After a final frame: line returns to idle and stays there.
    task automatic idle_check(input string tag, input int ncyc);
        int hi;
        @(negedge clk);
        check({tag, " done_low"}, 32'(o_tx_done), 32'd0);
        check({tag, " busy_low"}, 32'(o_tx_busy), 32'd0);
        check({tag, " idle_state"}, 32'(o_state), 32'd0);
        check({tag, " ready_hi"}, 32'(o_tx_ready), 32'd1);
        hi = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (o_txd && !o_tx_busy && !o_tx_done) hi++;
            @(negedge clk);
        end
        check({tag, " idle_line"}, 32'(hi), 32'(ncyc));
    endtask

    initial begin
        int bad;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        i_tx_start = 1'b0;
        i_tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst txd", 32'(o_txd), 32'd1);
        check("rst busy", 32'(o_tx_busy), 32'd0);
        check("rst done", 32'(o_tx_done), 32'd0);
        check("rst ready", 32'(o_tx_ready), 32'd1);
        check("rst state", 32'(o_state), 32'd0);

        // First accept on the first edge after release: 0xA5 single frame
        rst_n      = 1'b1;
        i_tx_start = 1'b1;
        i_tx_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        i_tx_start = 1'b0;
        watch_frame("a5", -1, 8'h00, -1, 8'h00, 1'b0, 100);
        idle_check("a5", 10);

        // Back-to-back 0x00 then 0xFF; 0x55 while holding is full is dropped
        request(8'h00);
        exp_q.push_back(8'hFF);
        watch_frame("b2b0", 30, 8'hFF, 60, 8'h55, 1'b0, 31);
        watch_frame("b2b1", -1, 8'h00, -1, 8'h00, 1'b0, 100);
        idle_check("b2b", 20);

        // Request on the last stop cycle with holding empty
        request(8'h5A);
        exp_q.push_back(8'h3C);
        watch_frame("last0", 99, 8'h3C, -1, 8'h00, 1'b0, 100);
        watch_frame("last1", -1, 8'h00, -1, 8'h00, 1'b0, 100);
        idle_check("last", 10);

        // Data input toggling after acceptance
        request(8'h96);
        watch_frame("tog", -1, 8'h00, -1, 8'h00, 1'b1, 100);
        idle_check("tog", 10);

        // Reset in the middle of data bit 4 of 0x81
        request(8'h81);
        repeat (54) @(negedge clk);
        check("mid txd", 32'(o_txd), 32'd0);
        check("mid state", 32'(o_state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst txd", 32'(o_txd), 32'd1);
        check("arst busy", 32'(o_tx_busy), 32'd0);
        check("arst done", 32'(o_tx_done), 32'd0);
        check("arst ready", 32'(o_tx_ready), 32'd1);
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_tx_done || !o_txd || o_tx_busy) bad++;
            @(negedge clk);
        end
        check("arst quiet", 32'(bad), 32'd0);
        request(8'h81);
        watch_frame("x81", -1, 8'h00, -1, 8'h00, 1'b0, 100);
        idle_check("x81", 10);

        check("queue empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
